c2_scatter: RTL and testbench
=============================

# c2_scatter

Registered 1-to-4 data distributor. It is the write-side counterpart of the registered four-input selector cell: one `size`-bit word goes to one of four holding registers (Q0..Q3), and the channel is chosen with the same four-bit select code (A1, B1, A0, B0) used on the selector side. Each channel has a valid flag with a per-channel read acknowledge, so a slow consumer can drain words independently. The block sits between a single producer and four downstream consumers in the datapath.

## Interface
Parameters:
- `size`, 5, data width in bits for D and Q0..Q3.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `CLRn`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `D`  in  size  write data word.
- `A1`, `B1`, `A0`, `B0`  in  1 each  channel select code.
- `WE`  in  1  write request, sampled on the rising edge of `clk`.
- `RD`  in  4  per-channel read acknowledge; bit i consumes channel i.
- `RDY`  out  1  combinational; the current write can be accepted.
- `Q0`, `Q1`, `Q2`, `Q3`  out  size each  channel holding registers.
- `VLD`  out  4  per-channel valid flags, registered.
- `OCC`  out  3  registered count of set VLD bits, 0..4.
- `OVF`  out  1  sticky overwrite flag, registered.

## Operation
- Channel select: `sel = {A1|B1, A0&B0}`. sel=0 selects Q0 and sel=3 selects Q3. This is the same decode the selector cell uses, so a word written with a given code is read back through the selector with the same code.
- `RDY = ~VLD[sel] | RD[sel]`: the selected channel is either empty or is being drained in the same cycle.
- Write is accepted when `WE & RDY`. At that edge: `Q[sel] <= D` and `VLD[sel] <= 1`.
- Read: `RD[i] & VLD[i]` clears `VLD[i]` at the edge. `Q[i]` keeps its value after a read; it is not zeroed.
- `RD[i]` while `VLD[i]=0` is ignored and causes no error.
- Same-cycle write and read on one channel: the write is accepted, Q takes the new D, and VLD stays 1.
- Write and reads on different channels in the same cycle are all honoured independently.
- A write that is not accepted (`WE & ~RDY`) is dropped. Q, VLD and OCC are unchanged, and the producer must hold D and the select code until RDY=1.
- `OCC` is recomputed every cycle as the population count of the next-state VLD. It never exceeds 4 and never underflows.
- Select inputs and D are don't-care when `WE=0`.

## Timing
- Reset value of every output while `CLRn=0`, applied asynchronously: Q0..Q3=0, VLD=4'b0000, OCC=0, OVF=0. RDY therefore reads 1 during reset.
- Reset deassertion is synchronised externally. The first write can be accepted at the first rising edge after `CLRn` goes high.
- Write latency is 1 cycle. A write accepted at edge k is visible on Q[sel], VLD and OCC immediately after edge k.
- Read latency is 1 cycle. VLD[i] falls after the edge where RD[i] is sampled.
- RDY is combinational from the select code, VLD and RD. There is no registered path from WE to RDY.
- If reset is asserted mid-operation, all pending words are discarded immediately. No partial update occurs at the coincident edge.

## Configuration
- Macro: `C2_SCATTER_OVERWRITE_EN`.
- Without the macro: behaviour is as above. OVF is tied to 0 and a write to a full, undrained channel is refused through RDY.
- With the macro:
  - RDY is tied to 1, and every `WE` is accepted.
  - A write to a channel with `VLD[sel]=1` and `RD[sel]=0` overwrites Q[sel] and sets OVF=1 at that edge.
  - OVF stays 1 until reset; no other event clears it.
  - VLD and OCC rules are unchanged.

## Test plan
- Reset: drive `CLRn=0` mid-cycle after loading Q2=5'h0A. Required: Q0..Q3=0, VLD=0000, OCC=0 and OVF=0 immediately, with no clock edge.
- Fill all channels: write D=1,2,3,4 with codes (A1,B1,A0,B0) = 0000, 0011, 1000, 0111. Required: Q0=1, Q1=2, Q2=3, Q3=4, VLD=1111, OCC=4.
- Backpressure (macro off): with channel 2 full, set WE=1, D=9, code 0100. Required: RDY=0, Q2 stays 3, OCC stays 4, OVF=0.
- Same-cycle read and write: from the full state, WE=1, D=5'h1F, code 1000, RD=0100. Required: RDY=1, Q2=5'h1F, VLD=1111, OCC=4.
- Drain: RD=1111 for one cycle, then RD=0001 again. Required: VLD=0000 and OCC=0 after the first edge, nothing changes after the second, and Q values are retained.
- Overwrite (macro on): with channel 0 full, write D=7 with code 0000 and RD=0. Required: RDY=1, Q0=7, OVF=1. OVF stays 1 after later reads.

Source files
------------

// File: rtl/c2_scatter_if.sv
// Producer/consumer bundle for c2_scatter: write word, select code,
// per-channel read acknowledges and the four holding registers.
interface c2_scatter_if #(parameter int unsigned size = 5);
  logic [size-1:0] D;
  logic            A1;
  logic            B1;
  logic            A0;
  logic            B0;
  logic            WE;
  logic [3:0]      RD;
  logic            RDY;
  logic [size-1:0] Q0;
  logic [size-1:0] Q1;
  logic [size-1:0] Q2;
  logic [size-1:0] Q3;
  logic [3:0]      VLD;
  logic [2:0]      OCC;
  logic            OVF;

  modport master (
    output D, A1, B1, A0, B0, WE, RD,
    input  RDY, Q0, Q1, Q2, Q3, VLD, OCC, OVF
  );

  modport slave (
    input  D, A1, B1, A0, B0, WE, RD,
    output RDY, Q0, Q1, Q2, Q3, VLD, OCC, OVF
  );
endinterface

// File: rtl/c2_scatter.sv
// Registered 1-to-4 data distributor with per-channel valid/read-ack.
// Optional macro C2_SCATTER_OVERWRITE_EN: always accept writes, flag overwrites in OVF.
module c2_scatter #(
  parameter int unsigned size = 5
) (
  input logic         clk,
  input logic         CLRn,
  c2_scatter_if.slave bus
);

  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;
  localparam int unsigned OCCW = 3;

  logic [size-1:0] q_q [NCH];
  logic [NCH-1:0]  vld_q;
  logic [NCH-1:0]  vld_nxt;
  logic [OCCW-1:0] occ_q;
  logic [OCCW-1:0] occ_nxt;
  logic            ovf_q;
  logic            ovf_nxt;
  logic [SELW-1:0] sel_c;
  logic            rdy_c;
  logic            wr_c;

  // Same decode as the selector cell so codes round-trip between the two.
  assign sel_c = {bus.A1 | bus.B1, bus.A0 & bus.B0};

`ifdef C2_SCATTER_OVERWRITE_EN
  assign rdy_c = 1'b1;
`else
  assign rdy_c = ~vld_q[sel_c] | bus.RD[sel_c];
`endif

  assign wr_c = bus.WE & rdy_c;

  // Next-state valid flags, occupancy and overwrite flag.
  always_comb begin
    vld_nxt = vld_q & ~bus.RD;
    if (wr_c) begin
      vld_nxt[sel_c] = 1'b1;
    end
    occ_nxt = OCCW'($countones(vld_nxt));
`ifdef C2_SCATTER_OVERWRITE_EN
    ovf_nxt = ovf_q | (bus.WE & vld_q[sel_c] & ~bus.RD[sel_c]);
`else
    ovf_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge CLRn) begin
    if (!CLRn) begin
      q_q   <= '{default: '0};
      vld_q <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_nxt;
      occ_q <= occ_nxt;
      ovf_q <= ovf_nxt;
      if (wr_c) begin
        q_q[sel_c] <= bus.D;
      end
    end
  end

  assign bus.RDY = rdy_c;
  assign bus.Q0  = q_q[0];
  assign bus.Q1  = q_q[1];
  assign bus.Q2  = q_q[2];
  assign bus.Q3  = q_q[3];
  assign bus.VLD = vld_q;
  assign bus.OCC = occ_q;
  assign bus.OVF = ovf_q;

endmodule

// File: tb/tb_c2_scatter.sv
// Scoreboard bench for c2_scatter: stimulus pushes model expectations,
// a monitor pops and compares after each clock edge.
module tb_c2_scatter;

  localparam int unsigned W = 5;

  typedef struct packed {
    logic              rdy;
    logic [3:0][W-1:0] q;
    logic [3:0]        vld;
    logic [2:0]        occ;
    logic              ovf;
  } exp_t;

  logic clk;
  logic CLRn;

  c2_scatter_if #(.size(W)) bus ();

  c2_scatter #(.size(W)) dut (
    .clk  (clk),
    .CLRn (CLRn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  event drv_ev;

  // Reference state: what each consumer would currently see.
  logic [W-1:0] m_q   [4];
  bit           m_vld [4];
  bit           m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_q[i]   = '0;
      m_vld[i] = 1'b0;
    end
    m_ovf = 1'b0;
  endfunction

  function automatic exp_t model_step(input bit we, input logic [W-1:0] d,
                                      input logic [3:0] code, input logic [3:0] rd);
    exp_t e;
    int   sel;
    bit   full;
    bit   rdy;
    int   cnt;
    sel  = ((code[3] | code[2]) ? 2 : 0) + ((code[1] & code[0]) ? 1 : 0);
    full = m_vld[sel] && !rd[sel];
`ifdef C2_SCATTER_OVERWRITE_EN
    rdy = 1'b1;
    if (we && full) m_ovf = 1'b1;
`else
    rdy = !full;
`endif
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) m_vld[i] = 1'b0;
    end
    if (we && rdy) begin
      m_q[sel]   = d;
      m_vld[sel] = 1'b1;
    end
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      e.q[i]   = m_q[i];
      e.vld[i] = m_vld[i];
      if (m_vld[i]) cnt++;
    end
    e.rdy = rdy;
    e.occ = 3'(cnt);
    e.ovf = m_ovf;
    return e;
  endfunction

  task automatic drive_idle();
    bus.WE = 1'b0;
    bus.D  = '0;
    {bus.A1, bus.B1, bus.A0, bus.B0} = 4'b0000;
    bus.RD = 4'b0000;
  endtask

  // code is {A1,B1,A0,B0}
  task automatic step(input bit we, input logic [W-1:0] d,
                      input logic [3:0] code, input logic [3:0] rd);
    @(negedge clk);
    bus.WE = we;
    bus.D  = d;
    {bus.A1, bus.B1, bus.A0, bus.B0} = code;
    bus.RD = rd;
    exp_q.push_back(model_step(we, d, code, rd));
    ->drv_ev;
  endtask

  // Monitor: RDY just before the edge, registered outputs just after.
  initial begin : monitor
    exp_t e;
    logic rdy_obs;
    forever begin
      @(drv_ev);
      #1;
      rdy_obs = bus.RDY;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_underrun", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("RDY", 32'(rdy_obs), 32'(e.rdy));
        chk("Q0",  32'(bus.Q0),  32'(e.q[0]));
        chk("Q1",  32'(bus.Q1),  32'(e.q[1]));
        chk("Q2",  32'(bus.Q2),  32'(e.q[2]));
        chk("Q3",  32'(bus.Q3),  32'(e.q[3]));
        chk("VLD", 32'(bus.VLD), 32'(e.vld));
        chk("OCC", 32'(bus.OCC), 32'(e.occ));
        chk("OVF", 32'(bus.OVF), 32'(e.ovf));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_Q0"},  32'(bus.Q0),  32'd0);
    chk({tag, "_Q1"},  32'(bus.Q1),  32'd0);
    chk({tag, "_Q2"},  32'(bus.Q2),  32'd0);
    chk({tag, "_Q3"},  32'(bus.Q3),  32'd0);
    chk({tag, "_VLD"}, 32'(bus.VLD), 32'd0);
    chk({tag, "_OCC"}, 32'(bus.OCC), 32'd0);
    chk({tag, "_OVF"}, 32'(bus.OVF), 32'd0);
    chk({tag, "_RDY"}, 32'(bus.RDY), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : stimulus
    bit           we;
    logic [W-1:0] d;
    logic [3:0]   code;
    logic [3:0]   rd;

    CLRn = 1'b0;
    drive_idle();
    model_reset();
    #1;
    chk_reset_outputs("por");

    @(negedge clk);
    CLRn = 1'b1;

    // Load Q2 then assert reset mid-cycle; outputs must clear without an edge.
    step(1'b1, 5'h0A, 4'b1000, 4'b0000);
    @(posedge clk);
    #3;
    drive_idle();
    CLRn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    CLRn = 1'b1;

    // Fill all four channels.
    step(1'b1, 5'd1, 4'b0000, 4'b0000);
    step(1'b1, 5'd2, 4'b0011, 4'b0000);
    step(1'b1, 5'd3, 4'b1000, 4'b0000);
    step(1'b1, 5'd4, 4'b0111, 4'b0000);
    // Write to full channel 2 without a read.
    step(1'b1, 5'd9, 4'b0100, 4'b0000);
    // Same-cycle read and write on channel 2.
    step(1'b1, 5'h1F, 4'b1000, 4'b0100);
    // Drain everything, then a stray read on an empty channel.
    step(1'b0, 5'd0, 4'b0000, 4'b1111);
    step(1'b0, 5'd0, 4'b0000, 4'b0001);
    // Fill channel 0, then write it again without draining.
    step(1'b1, 5'd1, 4'b0000, 4'b0000);
    step(1'b1, 5'd7, 4'b0000, 4'b0000);
    // Later reads: OVF must not clear.
    step(1'b0, 5'd0, 4'b0000, 4'b0001);
    step(1'b0, 5'd0, 4'b0000, 4'b1111);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      we   = ($urandom_range(0, 3) != 0);
      d    = W'($urandom);
      code = 4'($urandom);
      rd   = 4'($urandom) & 4'($urandom);
      step(we, d, code, rd);
    end

    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #3;
    chk("sb_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
